// File: rtl/ctrl_multiciclo.sv
// Multicycle processor control unit.
// Moore-style FSM that sequences fetch, decode, memory, ALU, branch, jump,
// set and halt phases, plus a counter of retired instructions.
// The only Mealy outputs are the memory-ready gating in FETCH, the
// zero-flag gating of PCWrite in BRANCH, and the OPcode-driven ALU controls
// in EXEC.
//
// Ports:
//   clock        sole clock, rising edge
//   Reset        synchronous active-low reset
//   OPcode[3:0]  instruction opcode field, valid from DECODE onward
//   zero         ALU zero flag, used in BRANCH
//   mem_ready    memory access completes this cycle
//   MemRead, MemWrite, IorD, IRWrite, PCWrite, EscReg, RegFonte,
//   UlaFonte1, CtrlUla, halted          1-bit datapath controls and status
//   UlaFonte2[1:0], PCFonte[1:0]        ALU operand B and PC source selects
//   estado[3:0]                         current state code
//   instr_count[CNT_W-1:0]              retired-instruction count
module ctrl_multiciclo #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [3:0]       OPcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             EscReg,
    output logic             RegFonte,
    output logic             UlaFonte1,
    output logic             CtrlUla,
    output logic             halted,
    output logic [1:0]       UlaFonte2,
    output logic [1:0]       PCFonte,
    output logic [3:0]       estado,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StAddr   = 4'd2,
        StMemRd  = 4'd3,
        StMemWr  = 4'd4,
        StWbMem  = 4'd5,
        StExec   = 4'd6,
        StWbAlu  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StSet    = 4'd10,
        StHalt   = 4'd11
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    // State register and retired-instruction counter; reset wins over
    // every transition, including HALT and memory waits.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CntOne;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        EscReg    = 1'b0;
        RegFonte  = 1'b0;
        UlaFonte1 = 1'b0;
        CtrlUla   = 1'b0;
        halted    = 1'b0;
        UlaFonte2 = 2'b00;
        PCFonte   = 2'b00;

        case (state_q)
            StFetch: begin
                // PC + 1 computed every cycle; committed only with the fetch.
                MemRead   = 1'b1;
                UlaFonte2 = 2'b01;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Branch target precomputed into ALUOut.
                UlaFonte2 = 2'b11;
                casez (OPcode)
                    4'b111?:          state_d = StSet;
                    4'b110?:          state_d = StJump;
                    4'b10??, 4'b01??: state_d = StAddr;
                    4'b0000:          state_d = StBranch;
                    4'b0001, 4'b0010: state_d = StExec;
                    default:          state_d = StHalt;
                endcase
            end
            StAddr: begin
                UlaFonte1 = 1'b1;
                UlaFonte2 = 2'b10;
                state_d   = OPcode[3] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StWbMem: begin
                EscReg  = 1'b1;
                state_d = StFetch;
                retire  = 1'b1;
            end
            StExec: begin
                // OPcode[1] selects subi (imm, subtract) over add (reg, add).
                UlaFonte1 = 1'b1;
                CtrlUla   = OPcode[1];
                UlaFonte2 = OPcode[1] ? 2'b10 : 2'b00;
                state_d   = StWbAlu;
            end
            StWbAlu: begin
                EscReg   = 1'b1;
                RegFonte = 1'b1;
                state_d  = StFetch;
                retire   = 1'b1;
            end
            StBranch: begin
                UlaFonte1 = 1'b1;
                CtrlUla   = 1'b1;
                PCFonte   = 2'b01;
                PCWrite   = zero;
                state_d   = StFetch;
                retire    = 1'b1;
            end
            StJump: begin
                PCWrite = 1'b1;
                PCFonte = 2'b10;
                state_d = StFetch;
                retire  = 1'b1;
            end
            StSet: begin
                UlaFonte2 = 2'b01;
                EscReg    = 1'b1;
                RegFonte  = 1'b1;
                state_d   = StFetch;
                retire    = 1'b1;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                // Unused codes recover to FETCH without side effects.
                state_d = StFetch;
            end
        endcase
    end

    assign estado      = state_q;
    assign instr_count = count_q;

endmodule
